// File: rtl/ysyx_25040109_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_25040109_mem_arbiter_if
// Bundles every bus the memory arbiter touches.
//   IFU read port : ifu_ren/ifu_raddr/ifu_rready in, ifu_rdata/ifu_rvalid out
//   LSU read port : lsu_ren/lsu_raddr/lsu_rready in, lsu_rdata/lsu_rvalid out
//   LSU write port: lsu_wvalid/lsu_waddr/lsu_wdata/lsu_wlen in, lsu_wready out
//   Memory read   : mem_ren/mem_raddr/mem_rready out, mem_rdata/mem_rvalid in
//   Memory write  : mem_wvalid/mem_waddr/mem_wdata/mem_wlen out, mem_wready in
// Modports:
//   slave  - the arbiter: serves the requesters and drives the memory side
//   master - the environment: the requesters plus the memory
// ----------------------------------------------------------------------------
interface ysyx_25040109_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ifu_ren;
    logic [AW-1:0] ifu_raddr;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_rvalid;
    logic          ifu_rready;

    logic          lsu_ren;
    logic [AW-1:0] lsu_raddr;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_rvalid;
    logic          lsu_rready;

    logic          lsu_wvalid;
    logic [AW-1:0] lsu_waddr;
    logic [DW-1:0] lsu_wdata;
    logic [2:0]    lsu_wlen;
    logic          lsu_wready;

    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          mem_rready;

    logic          mem_wvalid;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_wlen;
    logic          mem_wready;

    modport slave (
        input  ifu_ren, ifu_raddr, ifu_rready,
        output ifu_rdata, ifu_rvalid,
        input  lsu_ren, lsu_raddr, lsu_rready,
        output lsu_rdata, lsu_rvalid,
        input  lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wlen,
        output lsu_wready,
        output mem_ren, mem_raddr, mem_rready,
        input  mem_rdata, mem_rvalid,
        output mem_wvalid, mem_waddr, mem_wdata, mem_wlen,
        input  mem_wready
    );

    modport master (
        output ifu_ren, ifu_raddr, ifu_rready,
        input  ifu_rdata, ifu_rvalid,
        output lsu_ren, lsu_raddr, lsu_rready,
        input  lsu_rdata, lsu_rvalid,
        output lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wlen,
        input  lsu_wready,
        input  mem_ren, mem_raddr, mem_rready,
        output mem_rdata, mem_rvalid,
        input  mem_wvalid, mem_waddr, mem_wdata, mem_wlen,
        output mem_wready
    );
endinterface

// File: rtl/ysyx_25040109_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25040109_mem_arbiter
// Shares one memory port between the IFU (reads) and the LSU (reads/writes).
// One transaction is outstanding at a time. Requests are sampled in IDLE and
// the winner's state is entered on the next edge; IFU vs LSU ties are broken
// round-robin, and inside the LSU a write beats a read.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - requester and memory buses (slave modport)
//   busy - high whenever the arbiter is not IDLE
// ----------------------------------------------------------------------------
module ysyx_25040109_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    ysyx_25040109_mem_arbiter_if.slave         bus,
    output logic                               busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    wlen_q, wlen_d;

    logic          lsu_req;
    logic          ifu_wins;
    logic          rd_done;
    logic          wr_done;

    assign lsu_req  = bus.lsu_wvalid || bus.lsu_ren;
    // A lone IFU request wins; on a tie the IFU wins only if the LSU went last.
    assign ifu_wins = bus.ifu_ren && (!lsu_req || (last_grant_q == GRANT_LSU));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IFU;
            addr_q       <= '0;
            wdata_q      <= '0;
            wlen_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wlen_q       <= wlen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wlen_d       = wlen_q;

        // Memory side is always driven from the latches, never from live inputs.
        bus.mem_ren    = 1'b0;
        bus.mem_raddr  = addr_q;
        bus.mem_rready = 1'b0;
        bus.mem_wvalid = 1'b0;
        bus.mem_waddr  = addr_q;
        bus.mem_wdata  = wdata_q;
        bus.mem_wlen   = wlen_q;

        bus.ifu_rvalid = 1'b0;
        bus.ifu_rdata  = '0;
        bus.lsu_rvalid = 1'b0;
        bus.lsu_rdata  = '0;
        bus.lsu_wready = 1'b0;

        rd_done = 1'b0;
        wr_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (ifu_wins) begin
                    state_d = IFU_RD;
                    addr_d  = bus.ifu_raddr;
                end else if (bus.lsu_wvalid) begin
                    state_d = LSU_WR;
                    addr_d  = bus.lsu_waddr;
                    wdata_d = bus.lsu_wdata;
                    wlen_d  = bus.lsu_wlen;
                end else if (bus.lsu_ren) begin
                    state_d = LSU_RD;
                    addr_d  = bus.lsu_raddr;
                end
            end
            IFU_RD: begin
                bus.mem_ren    = 1'b1;
                bus.mem_rready = bus.ifu_rready;
                // A response arriving while reset is asserted is dropped.
                bus.ifu_rvalid = bus.mem_rvalid && !rst;
                bus.ifu_rdata  = bus.mem_rdata;
                rd_done        = bus.mem_rvalid && bus.ifu_rready;
                if (rd_done) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_IFU;
                end
            end
            LSU_RD: begin
                bus.mem_ren    = 1'b1;
                bus.mem_rready = bus.lsu_rready;
                bus.lsu_rvalid = bus.mem_rvalid && !rst;
                bus.lsu_rdata  = bus.mem_rdata;
                rd_done        = bus.mem_rvalid && bus.lsu_rready;
                if (rd_done) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_LSU;
                end
            end
            LSU_WR: begin
                bus.mem_wvalid = 1'b1;
                bus.lsu_wready = bus.mem_wready && !rst;
                wr_done        = bus.mem_wready;
                if (wr_done) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_LSU;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_25040109_mem_arbiter.sv
module tb_ysyx_25040109_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ysyx_25040109_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    ysyx_25040109_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    // Drive inputs 1 time unit after the rising edge, sample on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.ifu_ren = 0; bus.ifu_raddr = 0; bus.ifu_rready = 0;
        bus.lsu_ren = 0; bus.lsu_raddr = 0; bus.lsu_rready = 0;
        bus.lsu_wvalid = 0; bus.lsu_waddr = 0; bus.lsu_wdata = 0; bus.lsu_wlen = 0;
        bus.mem_rdata = 0; bus.mem_rvalid = 0; bus.mem_wready = 0;

        // ---- reset state
        nxt(); nxt();
        smp();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
        chk("rst_mem_wvalid", {31'd0, bus.mem_wvalid}, 32'd0);
        chk("rst_mem_rready", {31'd0, bus.mem_rready}, 32'd0);
        chk("rst_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'd0);
        chk("rst_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
        chk("rst_lsu_wready", {31'd0, bus.lsu_wready}, 32'd0);
        chk("rst_mem_raddr", bus.mem_raddr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        nxt();
        rst = 0;

        // ---- lone IFU read, memory answers on the third cycle of IFU_RD
        nxt();
        bus.ifu_ren = 1; bus.ifu_raddr = 32'h8000_0000; bus.ifu_rready = 1;
        smp();
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        nxt();
        bus.ifu_ren = 0;
        smp();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_mem_ren", {31'd0, bus.mem_ren}, 32'd1);
        chk("t1_mem_raddr", bus.mem_raddr, 32'h8000_0000);
        chk("t1_mem_rready", {31'd0, bus.mem_rready}, 32'd1);
        chk("t1_wait_rvalid", {31'd0, bus.ifu_rvalid}, 32'd0);
        nxt();
        smp();
        chk("t1_wait2_busy", {31'd0, busy}, 32'd1);
        nxt();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0413;
        smp();
        chk("t1_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'd1);
        chk("t1_ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
        chk("t1_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
        chk("t1_lsu_rdata", bus.lsu_rdata, 32'd0);
        nxt();
        // stray memory response while IDLE must be ignored
        bus.mem_rdata = 32'h0000_0999;
        smp();
        chk("t1_idle_busy2", {31'd0, busy}, 32'd0);
        chk("t1_stray_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'd0);
        chk("t1_stray_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
        chk("t1_idle_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
        chk("t1_idle_raddr_hold", bus.mem_raddr, 32'h8000_0000);
        nxt();
        bus.mem_rvalid = 0;

        // ---- round-robin ties after a fresh reset: LSU, IFU, LSU
        rst = 1;
        nxt();
        rst = 0;
        bus.ifu_ren = 1; bus.ifu_raddr = 32'h100;
        bus.lsu_ren = 1; bus.lsu_raddr = 32'h200; bus.lsu_rready = 1;
        nxt();
        smp();
        chk("t2_first_raddr", bus.mem_raddr, 32'h200);
        nxt();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_AAAA;
        smp();
        chk("t2_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd1);
        chk("t2_lsu_rdata", bus.lsu_rdata, 32'h0000_AAAA);
        chk("t2_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'd0);
        chk("t2_ifu_rdata", bus.ifu_rdata, 32'd0);
        nxt();
        bus.mem_rvalid = 0;
        smp();
        chk("t2_gap_busy", {31'd0, busy}, 32'd0);
        nxt();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_BBBB;
        smp();
        chk("t2_second_raddr", bus.mem_raddr, 32'h100);
        chk("t2_second_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'd1);
        chk("t2_second_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
        nxt();
        bus.mem_rvalid = 0;
        nxt();
        bus.ifu_ren = 0; bus.lsu_ren = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_CCCC;
        smp();
        chk("t2_third_raddr", bus.mem_raddr, 32'h200);
        chk("t2_third_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd1);
        nxt();
        bus.mem_rvalid = 0;
        smp();
        chk("t2_end_busy", {31'd0, busy}, 32'd0);

        // ---- LSU byte write with 4 cycles of back-pressure
        nxt();
        bus.lsu_wvalid = 1; bus.lsu_waddr = 32'h8000_1000;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wlen = 3'b001;
        nxt();
        // live inputs change; memory side must keep the latched values
        bus.lsu_wvalid = 0; bus.lsu_waddr = 32'h0; bus.lsu_wdata = 32'h0; bus.lsu_wlen = 3'b100;
        for (int i = 0; i < 5; i++) begin
            bus.mem_wready = (i == 4);
            smp();
            chk("t3_mem_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
            chk("t3_mem_waddr", bus.mem_waddr, 32'h8000_1000);
            chk("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t3_mem_wlen", {29'd0, bus.mem_wlen}, 32'd1);
            chk("t3_lsu_wready", {31'd0, bus.lsu_wready}, (i == 4) ? 32'd1 : 32'd0);
            nxt();
        end
        bus.mem_wready = 0;
        smp();
        chk("t3_done_wvalid", {31'd0, bus.mem_wvalid}, 32'd0);
        chk("t3_done_wready", {31'd0, bus.lsu_wready}, 32'd0);
        chk("t3_done_busy", {31'd0, busy}, 32'd0);

        // ---- LSU write beats LSU read
        nxt();
        bus.lsu_wvalid = 1; bus.lsu_waddr = 32'h300; bus.lsu_wdata = 32'h1234_5678; bus.lsu_wlen = 3'b100;
        bus.lsu_ren = 1; bus.lsu_raddr = 32'h400; bus.lsu_rready = 1;
        nxt();
        bus.lsu_wvalid = 0; bus.mem_wready = 1;
        smp();
        chk("t4_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
        chk("t4_ren", {31'd0, bus.mem_ren}, 32'd0);
        chk("t4_waddr", bus.mem_waddr, 32'h300);
        chk("t4_wready", {31'd0, bus.lsu_wready}, 32'd1);
        nxt();
        bus.mem_wready = 0;
        nxt();
        bus.lsu_ren = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0055;
        bus.mem_wready = 1;  // wrong-kind response during a read
        smp();
        chk("t4_rd_ren", {31'd0, bus.mem_ren}, 32'd1);
        chk("t4_rd_raddr", bus.mem_raddr, 32'h400);
        chk("t4_rd_rvalid", {31'd0, bus.lsu_rvalid}, 32'd1);
        chk("t4_rd_rdata", bus.lsu_rdata, 32'h0000_0055);
        chk("t4_rd_stray_wready", {31'd0, bus.lsu_wready}, 32'd0);
        nxt();
        bus.mem_rvalid = 0; bus.mem_wready = 0;

        // ---- IFU address changes and ren drops mid-transaction
        nxt();
        bus.ifu_ren = 1; bus.ifu_raddr = 32'h8000_0040; bus.ifu_rready = 1;
        nxt();
        bus.ifu_ren = 0; bus.ifu_raddr = 32'h1234_5678;
        smp();
        chk("t5_raddr_a", bus.mem_raddr, 32'h8000_0040);
        nxt();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0777;
        smp();
        chk("t5_raddr_b", bus.mem_raddr, 32'h8000_0040);
        chk("t5_ifu_rvalid", {31'd0, bus.ifu_rvalid}, 32'd1);
        chk("t5_ifu_rdata", bus.ifu_rdata, 32'h0000_0777);
        nxt();
        bus.mem_rvalid = 0;
        smp();
        chk("t5_done_busy", {31'd0, busy}, 32'd0);

        // ---- reset during LSU_RD with a response arriving the same cycle
        nxt();
        bus.lsu_ren = 1; bus.lsu_raddr = 32'h500;
        nxt();
        bus.lsu_ren = 0;
        smp();
        chk("t6_busy", {31'd0, busy}, 32'd1);
        nxt();
        rst = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0666;
        smp();
        chk("t6_rst_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
        nxt();
        smp();
        chk("t6_after_busy", {31'd0, busy}, 32'd0);
        chk("t6_after_lsu_rvalid", {31'd0, bus.lsu_rvalid}, 32'd0);
        chk("t6_after_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
        nxt();
        rst = 0; bus.mem_rvalid = 0;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_25040109_mem_arbiter.md
YSYX_25040109_MEM_ARBITER -- requirements
Module: ysyx_25040109_mem_arbiter

Interface
REQ-001 SHALL have parameter: AW, 32, address width.
REQ-002 SHALL have parameter: DW, 32, data width.
REQ-003 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have IFU read port: ifu_ren in 1, ifu_raddr in AW, ifu_rdata out DW, ifu_rvalid out 1, ifu_rready in 1.
REQ-006 SHALL have LSU read port: lsu_ren in 1, lsu_raddr in AW, lsu_rdata out DW, lsu_rvalid out 1, lsu_rready in 1.
REQ-007 SHALL have LSU write port: lsu_wvalid in 1, lsu_waddr in AW, lsu_wdata in DW, lsu_wlen in 3 (001 byte, 010 half, 100 word), lsu_wready out 1.
REQ-008 SHALL have memory read port: mem_ren out 1, mem_raddr out AW, mem_rdata in DW, mem_rvalid in 1, mem_rready out 1.
REQ-009 SHALL have memory write port: mem_wvalid out 1, mem_waddr out AW, mem_wdata out DW, mem_wlen out 3, mem_wready in 1.
REQ-010 SHALL have busy out 1, high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, IFU_RD, LSU_RD, LSU_WR; exactly one transaction outstanding at a time.
REQ-012 In IDLE, SHALL sample requests ifu_ren, lsu_ren, lsu_wvalid and register the grant; the granted state is entered on the next edge (1-cycle arbitration latency).
REQ-013 LSU internal priority: lsu_wvalid over lsu_ren when both high.
REQ-014 IFU vs LSU: round-robin via 1-bit last_grant; the requester not granted last wins a tie; a lone requester always wins.
REQ-015 On grant, SHALL latch address, and for writes wdata and wlen; memory outputs are driven from the latches, not from live requester inputs.
REQ-016 IFU_RD/LSU_RD: mem_ren=1, mem_raddr=latched address; mem_rready = granted requester's rready; granted rvalid = mem_rvalid; granted rdata = mem_rdata.
REQ-017 LSU_WR: mem_wvalid=1 held until mem_wready; lsu_wready = mem_wready.
REQ-018 Completion: read on mem_rvalid&&mem_rready, write on mem_wvalid&&mem_wready; state returns to IDLE on that edge and last_grant updates.
REQ-019 Back-to-back: a request pending at completion is granted in the following IDLE cycle; minimum 1 IDLE cycle between transactions.
REQ-020 Non-granted ports: rvalid=0, wready=0, rdata=0; requests held, never dropped or reordered.
REQ-021 Requester deasserting ren/wvalid mid-transaction SHALL NOT abort it; transaction completes from latched values.
REQ-022 mem_rvalid/mem_wready arriving in IDLE or a non-matching state SHALL be ignored and not forwarded.
REQ-023 In IDLE all memory outputs deasserted (mem_ren=0, mem_wvalid=0, mem_rready=0); address/data outputs hold latched values.

Reset
REQ-024 rst high at any edge SHALL force IDLE, aborting any in-flight transaction, with no response forwarded.
REQ-025 Reset values: busy=0, mem_ren=0, mem_wvalid=0, mem_rready=0, ifu_rvalid=0, lsu_rvalid=0, lsu_wready=0, last_grant=IFU (LSU wins first tie), latches=0.

Verification
REQ-026 Lone IFU read addr 0x80000000, mem returns 0x00000413 after 3 cycles -> IFU_RD entered 1 cycle after ifu_ren, ifu_rvalid/ifu_rdata=0x00000413 one cycle, lsu_rvalid stays 0, IDLE next.
REQ-027 ifu_ren and lsu_ren high same cycle after reset -> LSU served first; IFU served next; third simultaneous tie -> LSU again.
REQ-028 LSU write addr 0x80001000 data 0xDEADBEEF wlen 001, mem_wready low 4 cycles -> mem_wvalid/addr/data/wlen stable all 5 cycles, lsu_wready pulses once on acceptance.
REQ-029 lsu_wvalid and lsu_ren high together -> write granted first, read next.
REQ-030 IFU read granted, ifu_raddr changed and ifu_ren dropped mid-wait -> mem_raddr keeps original address until completion.
REQ-031 rst asserted during LSU_RD with mem_rvalid high same cycle -> lsu_rvalid=0 after edge, state IDLE, busy=0.
